// File: rtl/mult_div_unit.sv
// mult_div_unit
// Iterative HI/LO multiply/divide stage sitting beside the ALU. A started
// operation runs one radix-2 step per clock (shift-add for MULT/MULTU,
// restoring division for DIV/DIVU) on unsigned magnitudes. The signs are
// re-applied when the result is written into HI/LO. busy stalls the PC while
// an operation is in flight. MTHI/MTLO writes are serviced whenever the unit
// is idle.
//
// Ports:
//   clk      - system clock, rising edge
//   nrst     - asynchronous active-low reset
//   start    - request a new operation (accepted only while idle)
//   op       - 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   a, b     - rs / rt operands, sampled only on the accepting edge
//   write_hi - MTHI: load HI from wdata (idle, no start accepted)
//   write_lo - MTLO: load LO from wdata (idle, no start accepted)
//   wdata    - MTHI/MTLO data
//   hi, lo   - architectural HI/LO registers
//   busy     - operation in progress
//   done     - one-cycle pulse when HI/LO take a new result
module mult_div_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 6
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  start,
  input  logic [1:0]            op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic                  write_hi,
  input  logic                  write_lo,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo,
  output logic                  busy,
  output logic                  done
);

  localparam int W = DATA_WIDTH;

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_e;

  state_e                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [2*W-1:0]         acc_q, acc_d;
  logic [W-1:0]           ma_q, ma_d;
  logic [W-1:0]           mb_q, mb_d;
  logic                   isDiv_q, isDiv_d;
  logic                   sa_q, sa_d;
  logic                   sb_q, sb_d;
  logic                   div0_q, div0_d;
  logic [W-1:0]           hi_q, hi_d;
  logic [W-1:0]           lo_q, lo_d;
  logic                   done_q, done_d;

  // Datapath helpers for the iteration and the final sign correction.
  logic                   inSignA, inSignB;
  logic [W-1:0]           inMagA, inMagB;
  logic [W:0]             mulSum;
  logic                   divFits;
  logic [W-1:0]           divDiff;
  logic [2*W-1:0]         mulResult;
  logic [W-1:0]           quotient, remainder, origA;

  always_comb begin
    inSignA   = ~op[0] & a[W-1];
    inSignB   = ~op[0] & b[W-1];
    // Negating 0x80000000 leaves 0x80000000, which is the correct magnitude
    // once it is read as unsigned.
    inMagA    = inSignA ? -a : a;
    inMagB    = inSignB ? -b : b;

    // Multiply step: add the multiplicand into the upper half when the
    // current multiplier bit (LSB) is set, keeping the carry for the shift.
    mulSum    = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, ma_q} : '0);

    // Divide step: the shifted partial remainder is W+1 bits wide. When the
    // divisor fits, the difference is always below 2^W, so W bits suffice.
    divFits   = acc_q[2*W-1:W-1] >= {1'b0, mb_q};
    divDiff   = acc_q[2*W-2:W-1] - mb_q;

    mulResult = (sa_q ^ sb_q) ? -acc_q : acc_q;
    quotient  = (sa_q ^ sb_q) ? -acc_q[W-1:0] : acc_q[W-1:0];
    remainder = sa_q ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];
    // Rebuild the untouched dividend for the divide-by-zero result.
    origA     = sa_q ? -ma_q : ma_q;
  end

  // Next-state logic. HI/LO only change on MTHI/MTLO in IDLE or on result
  // load in FIN, so intermediate values never appear on the outputs.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    ma_d    = ma_q;
    mb_d    = mb_q;
    isDiv_d = isDiv_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    div0_d  = div0_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          sa_d    = inSignA;
          sb_d    = inSignB;
          ma_d    = inMagA;
          mb_d    = inMagB;
          isDiv_d = op[1];
          div0_d  = (b == '0);
          cnt_d   = '0;
          // Multiply keeps the multiplier in the low half and shifts it
          // out; divide shifts the dividend into the remainder half.
          acc_d   = op[1] ? {{W{1'b0}}, inMagA} : {{W{1'b0}}, inMagB};
          state_d = RUN;
        end else begin
          if (write_hi) hi_d = wdata;
          if (write_lo) lo_d = wdata;
        end
      end

      RUN: begin
        cnt_d = cnt_q + CNT_WIDTH'(1);
        if (isDiv_q) begin
          if (divFits) acc_d = {divDiff, acc_q[W-2:0], 1'b1};
          else         acc_d = {acc_q[2*W-2:0], 1'b0};
        end else begin
          acc_d = {mulSum, acc_q[W-1:1]};
        end
        if (cnt_q == CNT_WIDTH'(W - 1)) state_d = FIN;
      end

      FIN: begin
        if (!isDiv_q) begin
          hi_d = mulResult[2*W-1:W];
          lo_d = mulResult[W-1:0];
        end else if (div0_q) begin
          hi_d = origA;
          lo_d = '1;
        end else begin
          hi_d = remainder;
          lo_d = quotient;
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // State register; reset discards any partial operation.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      ma_q    <= '0;
      mb_q    <= '0;
      isDiv_q <= 1'b0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      div0_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      ma_q    <= ma_d;
      mb_q    <= mb_d;
      isDiv_q <= isDiv_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      div0_q  <= div0_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign busy = (state_q != IDLE);
  assign done = done_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit
// Self-checking bench for mult_div_unit. Each accepted operation pushes its
// expected {hi, lo} onto a queue; a monitor pops and compares whenever done
// pulses. The main sequence also checks reset values, latency, hold behaviour
// while busy, MTHI/MTLO and asynchronous reset mid-operation.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        nrst;
  logic        start;
  logic [1:0]  opIn;
  logic [31:0] aIn, bIn;
  logic        writeHi, writeLo;
  logic [31:0] wdata;
  logic [31:0] hi, lo;
  logic        busy, done;

  int numChecks = 0;
  int numFails  = 0;
  int resultIdx = 0;
  logic [63:0] expQ[$];

  mult_div_unit #(.DATA_WIDTH(32), .CNT_WIDTH(6)) dut (
    .clk(clk), .nrst(nrst), .start(start), .op(opIn), .a(aIn), .b(bIn),
    .write_hi(writeHi), .write_lo(writeLo), .wdata(wdata),
    .hi(hi), .lo(lo), .busy(busy), .done(done)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  // Reference model built on the language's own arithmetic operators.
  function automatic logic [63:0] model(input logic [1:0] op,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    p  = '0;
    case (op)
      2'b00: p = sa * sb;
      2'b01: p = {32'b0, a} * {32'b0, b};
      2'b10: begin
        if (b == 32'd0) p = {a, 32'hFFFFFFFF};
        else begin
          q = sa / sb;
          r = sa % sb;
          p = {r[31:0], q[31:0]};
        end
      end
      default: begin
        if (b == 32'd0) p = {a, 32'hFFFFFFFF};
        else            p = {a % b, a / b};
      end
    endcase
    return p;
  endfunction

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    numChecks++;
    if (observed !== expected) begin
      numFails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one accepted operation, then scramble the operand inputs so any
  // late sampling would corrupt the result.
  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a,
                               input logic [31:0] b);
    start = 1'b1;
    opIn  = op;
    aIn   = a;
    bIn   = b;
    expQ.push_back(model(op, a, b));
    tick();
    start = 1'b0;
    opIn  = 2'($urandom_range(0, 3));
    aIn   = $urandom;
    bIn   = $urandom;
    checkOutput("busyAfterStart", {63'b0, busy}, 64'd1);
  endtask

  // Wait (bounded) for done and check the cycle count from the accepting edge.
  task automatic waitDone(input int startCount, input string tag);
    int n;
    n = startCount;
    while (done !== 1'b1 && n < 60) begin
      tick();
      n++;
    end
    checkOutput({tag, "_latency"}, 64'(n), 64'd33);
    checkOutput({tag, "_busyLow"}, {63'b0, busy}, 64'd0);
  endtask

  // Scoreboard monitor: every done pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (nrst === 1'b1 && done === 1'b1) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpectedDone", 64'd1, 64'd0);
      end else begin
        checkOutput($sformatf("result%0d", resultIdx), {hi, lo}, expQ.pop_front());
        resultIdx++;
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    nrst = 1'b0; start = 1'b0; opIn = 2'b00; aIn = '0; bIn = '0;
    writeHi = 1'b0; writeLo = 1'b0; wdata = '0;
    tick();
    tick();
    checkOutput("resetHi",   {32'b0, hi}, 64'd0);
    checkOutput("resetLo",   {32'b0, lo}, 64'd0);
    checkOutput("resetBusy", {63'b0, busy}, 64'd0);
    checkOutput("resetDone", {63'b0, done}, 64'd0);
    nrst = 1'b1;
    tick();

    // MULTU of the largest operands, with a single-cycle done pulse.
    applyStimulus(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
    waitDone(0, "multu");
    checkOutput("multuHi", {32'b0, hi}, 64'hFFFFFFFE);
    checkOutput("multuLo", {32'b0, lo}, 64'h00000001);
    tick();
    checkOutput("donePulseWidth", {63'b0, done}, 64'd0);

    // MULT with mixed signs, then DIV issued in the done cycle.
    applyStimulus(2'b00, 32'hFFFFFFFD, 32'd7);
    waitDone(0, "mult");
    applyStimulus(2'b10, 32'hFFFFFFF9, 32'd2);
    waitDone(0, "divBackToBack");
    checkOutput("divLo", {32'b0, lo}, 64'hFFFFFFFD);
    checkOutput("divHi", {32'b0, hi}, 64'hFFFFFFFF);

    // Divide by zero and the overflow corner.
    tick();
    applyStimulus(2'b11, 32'd100, 32'd0);
    waitDone(0, "divuByZero");
    applyStimulus(2'b10, 32'h80000000, 32'hFFFFFFFF);
    waitDone(0, "divOverflow");

    // Start and MTHI while busy must be ignored; HI/LO hold meanwhile.
    tick();
    applyStimulus(2'b11, 32'd1000, 32'd7);
    repeat (9) tick();
    start = 1'b1; opIn = 2'b00; aIn = 32'd5; bIn = 32'd3;
    writeHi = 1'b1; wdata = 32'hDEAD;
    tick();
    start = 1'b0; writeHi = 1'b0;
    checkOutput("holdHi", {32'b0, hi}, 64'd0);
    checkOutput("holdLo", {32'b0, lo}, 64'h80000000);
    waitDone(10, "divuIgnoreStart");
    checkOutput("divuLo", {32'b0, lo}, 64'd142);
    checkOutput("divuHi", {32'b0, hi}, 64'd6);

    // Asynchronous reset in the middle of a MULT.
    tick();
    applyStimulus(2'b00, 32'h00012345, 32'h00006789);
    repeat (14) tick();
    nrst = 1'b0;
    #1;
    checkOutput("midResetHi",   {32'b0, hi}, 64'd0);
    checkOutput("midResetLo",   {32'b0, lo}, 64'd0);
    checkOutput("midResetBusy", {63'b0, busy}, 64'd0);
    checkOutput("midResetDone", {63'b0, done}, 64'd0);
    expQ.delete();
    tick();
    nrst = 1'b1;
    tick();

    // MTLO alone, then MTHI+MTLO together.
    writeLo = 1'b1; wdata = 32'h1234;
    tick();
    writeLo = 1'b0;
    checkOutput("mtloLo",   {32'b0, lo}, 64'h1234);
    checkOutput("mtloHi",   {32'b0, hi}, 64'd0);
    checkOutput("mtloDone", {63'b0, done}, 64'd0);
    writeHi = 1'b1; writeLo = 1'b1; wdata = 32'hABCD0001;
    tick();
    writeHi = 1'b0; writeLo = 1'b0;
    checkOutput("mtBothHi", {32'b0, hi}, 64'hABCD0001);
    checkOutput("mtBothLo", {32'b0, lo}, 64'hABCD0001);

    // A short run of random back-to-back operations.
    for (int i = 0; i < 6; i++) begin
      logic [31:0] rb;
      rb = (i == 3) ? 32'd0 : $urandom;
      if (i == 4) rb = 32'($urandom_range(1, 9));
      applyStimulus(2'(i % 4), $urandom, rb);
      waitDone(0, $sformatf("random%0d", i));
    end

    tick();
    checkOutput("queueEmpty", 64'(expQ.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

endmodule
